// File: rtl/state_event_pkg.sv
// Shared types for the push-button / decay strobe generator.
// The FSM, command kind and service source enums live here so the bench can decode them too.
package state_event_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } fsm_e;

  typedef enum logic {
    KIND_UP   = 1'b0,
    KIND_DOWN = 1'b1
  } kind_e;

  typedef enum logic [1:0] {
    SRC_UP    = 2'd0,
    SRC_DOWN  = 2'd1,
    SRC_DECAY = 2'd2
  } src_e;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int num);
    return (idx == IDX_W'(num - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge pulse for one raw button.
module debounce_sync #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only survives while the synchronized input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = level_q & ~prev_q;

endmodule

// File: rtl/state_event_gen.sv
// Turns debounced up/down/select buttons and a periodic decay tick into
// one-at-a-time (state, UpState/DownState) update commands with a setup cycle.
module state_event_gen
  import state_event_pkg::*;
#(
  parameter int DEB_CYCLES   = 16,
  parameter int DECAY_CYCLES = 64,
  parameter int NUM_STATES   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  input  logic             decay_en,
  output logic [IDX_W-1:0] state,
  output logic             UpState,
  output logic             DownState,
  output logic             busy
);

  localparam int DEC_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_CYCLES - 1);

  logic up_evt, down_evt, sel_evt, decay_evt;

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst(rst), .btn_i(btn_up), .rise_o(up_evt)
  );
  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst(rst), .btn_i(btn_down), .rise_o(down_evt)
  );
  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk(clk), .rst(rst), .btn_i(btn_sel), .rise_o(sel_evt)
  );

  fsm_e             fsm_q, fsm_d;
  kind_e            kind_q, kind_d;
  src_e             src_q, src_d;
  logic [IDX_W-1:0] tgt_q, tgt_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [IDX_W-1:0] decay_idx_q, decay_idx_d;
  logic [DEC_W-1:0] dcnt_q, dcnt_d;
  logic             pend_up_q, pend_up_d;
  logic             pend_down_q, pend_down_d;
  logic             pend_decay_q, pend_decay_d;
  logic             clr_up, clr_down, clr_decay;

  always_comb begin
    dcnt_d    = '0;
    decay_evt = 1'b0;
    if (decay_en) begin
      if (dcnt_q == DEC_LAST) decay_evt = 1'b1;
      else                    dcnt_d    = dcnt_q + DEC_W'(1);
    end
  end

  // A new event wins over a same-cycle clear so it is never lost.
  always_comb begin
    pend_up_d    = (pend_up_q    & ~clr_up)    | up_evt;
    pend_down_d  = (pend_down_q  & ~clr_down)  | down_evt;
    pend_decay_d = (pend_decay_q & ~clr_decay) | decay_evt;
    sel_idx_d    = sel_evt ? wrap_inc(sel_idx_q, NUM_STATES) : sel_idx_q;
  end

  always_comb begin
    fsm_d       = fsm_q;
    kind_d      = kind_q;
    src_d       = src_q;
    tgt_d       = tgt_q;
    decay_idx_d = decay_idx_q;
    clr_up      = 1'b0;
    clr_down    = 1'b0;
    clr_decay   = 1'b0;
    state       = sel_idx_q;
    UpState     = 1'b0;
    DownState   = 1'b0;
    busy        = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (pend_up_q) begin
          tgt_d  = sel_idx_q;
          kind_d = KIND_UP;
          src_d  = SRC_UP;
          fsm_d  = SETUP;
        end else if (pend_down_q) begin
          tgt_d  = sel_idx_q;
          kind_d = KIND_DOWN;
          src_d  = SRC_DOWN;
          fsm_d  = SETUP;
        end else if (pend_decay_q) begin
          tgt_d  = decay_idx_q;
          kind_d = KIND_DOWN;
          src_d  = SRC_DECAY;
          fsm_d  = SETUP;
        end
      end
      SETUP: begin
        state = tgt_q;
        busy  = 1'b1;
        fsm_d = STROBE;
      end
      STROBE: begin
        state     = tgt_q;
        busy      = 1'b1;
        UpState   = (kind_q == KIND_UP);
        DownState = (kind_q == KIND_DOWN);
        case (src_q)
          SRC_UP:   clr_up   = 1'b1;
          SRC_DOWN: clr_down = 1'b1;
          default: begin
            clr_decay   = 1'b1;
            decay_idx_d = wrap_inc(decay_idx_q, NUM_STATES);
          end
        endcase
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= IDLE;
      kind_q       <= KIND_UP;
      src_q        <= SRC_UP;
      tgt_q        <= '0;
      sel_idx_q    <= '0;
      decay_idx_q  <= '0;
      dcnt_q       <= '0;
      pend_up_q    <= 1'b0;
      pend_down_q  <= 1'b0;
      pend_decay_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      kind_q       <= kind_d;
      src_q        <= src_d;
      tgt_q        <= tgt_d;
      sel_idx_q    <= sel_idx_d;
      decay_idx_q  <= decay_idx_d;
      dcnt_q       <= dcnt_d;
      pend_up_q    <= pend_up_d;
      pend_down_q  <= pend_down_d;
      pend_decay_q <= pend_decay_d;
    end
  end

endmodule

// File: doc/state_event_gen.md
Name: state_event_gen

Overview:
- Upstream driver for Registro_states.
- Turns three raw push-buttons (up, down, select) and a periodic decay tick into strobed update commands: a 3-bit target index `state` plus one-cycle `UpState`/`DownState` pulses.
- Guarantees `state` is stable for one cycle before and during every strobe.
- Guarantees only one strobe is issued at a time.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronized samples required before a debounced level changes.
- DECAY_CYCLES, 64: clock cycles between decay requests while decay_en is high.
- NUM_STATES, 5: number of valid indices (2..8); indices wrap at NUM_STATES-1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw increment button, active-high, asynchronous.
- btn_down  in  1  raw decrement button, active-high, asynchronous.
- btn_sel  in  1  raw select button, active-high, asynchronous; advances the user index.
- decay_en  in  1  synchronous enable for the decay timer.
- state  out  3  target index presented to the register.
- UpState  out  1  one-cycle increment strobe.
- DownState  out  1  one-cycle decrement strobe.
- busy  out  1  high while the FSM is outside IDLE.

Behaviour:
- Reset (rst=0, async): all outputs 0; sel_idx=0, decay_idx=0; debounced levels 0; all counters 0; pending flags 0; FSM=IDLE. Strobes drop in the same instant reset asserts.
- Input conditioning, per button:
  - 2-FF synchronizer feeds the debouncer.
  - Debounce counter increments while the synchronized value differs from the debounced level, and clears otherwise.
  - On reaching DEB_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a one-cycle event.
- Select: sel event sets sel_idx <= (sel_idx==NUM_STATES-1) ? 0 : sel_idx+1. It produces no strobe.
- Decay timer:
  - While decay_en=1, counts 0..DECAY_CYCLES-1. At terminal count it raises a decay event and wraps to 0.
  - decay_en=0 holds the counter at 0. An already-pending decay is still serviced.
- Pending flags pend_up, pend_down, pend_decay:
  - Each is set by its event and cleared when serviced.
  - An event arriving while its own flag is set is merged, not queued.
- FSM (encoding IDLE, SETUP, STROBE):
  - IDLE:
    - If any flag is set, latch the target and kind, then go to SETUP.
    - Priority: up > down > decay.
    - Up/down target = sel_idx. Decay target = decay_idx, kind = down.
  - SETUP: state = latched target, strobes 0, busy=1. Next state is STROBE.
  - STROBE: state = latched target. Exactly one of UpState/DownState is 1. Clear the serviced flag. A decay service advances decay_idx with wrap at NUM_STATES-1. Next state is IDLE.
  - In IDLE, state = sel_idx.
- Latency: with the FSM idle, the strobe is high in the cycle beginning DEB_CYCLES+4 rising edges after the first edge that samples the raw button high.
- Throughput: at most one strobe every 3 cycles.
- Simultaneous events: up and down debounced in the same cycle set both flags. Up is served first, down on the next IDLE pass.
- sel change while busy: sel_idx updates immediately; the latched target is unaffected.
- Invariant: UpState & DownState is never 1.
- Invariant: state < NUM_STATES always.
- Bounce shorter than DEB_CYCLES cycles produces no event.
- Button held: one event per press. Release requires DEB_CYCLES stable-low samples before the next press is accepted.

Decomposition:
- Package state_event_pkg: FSM state enum (IDLE, SETUP, STROBE), IDX_W=3, kind encoding (KIND_UP, KIND_DOWN).
- Sub-module debounce_sync (synchronizer + debounce counter + rising-edge pulse), parameterised by DEB_CYCLES, instantiated three times.

Test Plan:
- Reset: hold rst=0 for 10 cycles with buttons toggling -> state=0, UpState=0, DownState=0, busy=0; release -> still 0 with no events.
- Clean press, DEB_CYCLES=4, decay_en=0: btn_up high from edge 0 -> UpState=1 for exactly one cycle at edge 8 with state=0 stable at edges 7 and 8; holding the button 50 cycles gives no second pulse.
- Bounce: btn_down toggled every 2 cycles for 20 cycles, then low -> no DownState pulse.
- Select wrap, NUM_STATES=5: six sel presses -> sel_idx sequence 1,2,3,4,0,1; then an up press -> UpState with state=1.
- Collision: btn_up and btn_down rise on the same edge -> UpState pulse, then DownState exactly 3 cycles later, both with state=sel_idx; never both high.
- Decay, DECAY_CYCLES=8, NUM_STATES=3: decay_en=1 for 40 cycles -> DownState pulses with state 0,1,2,0,… and consecutive pulses spaced 8 cycles apart. Assert rst=0 during SETUP -> strobe never issued, decay_idx back to 0.
